// File: rtl/uart_pkg.sv
// Shared UART definitions: framing limits, FSM state encoding and the
// parity helper used by both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_MIN_LEN       = 5;
    localparam int UART_MAX_LEN       = 8;
    localparam int UART_TICKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5,
        DONE   = 3'd6
    } uart_state_t;

    // Parity over the transmitted bits only (data[length-1:0]).
    // parity_type=1 gives XOR (odd count -> 1), parity_type=0 gives XNOR.
    function automatic logic uart_parity(input logic [7:0] data,
                                         input logic [3:0] length,
                                         input logic       parity_type);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < {28'd0, length}) begin
                p = p ^ data[i];
            end
        end
        return parity_type ? p : ~p;
    endfunction

    // True when a frame length can be transmitted.
    function automatic logic uart_len_ok(input logic [3:0] length);
        return (length >= 4'(UART_MIN_LEN)) && (length <= 4'(UART_MAX_LEN));
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side interface of the UART transmitter.
//
// Handshake: tx_start is a request that the transmitter samples only while
// idle (tx_busy=0 and tx_done=0). A request with a legal length is accepted
// on that edge and tx_busy rises in the next cycle; the framing inputs are
// captured at acceptance, so the host may change them freely afterwards.
// There is no separate ready: tx_busy=0 means a request will be sampled.
// tx_done pulses for one cycle when the last stop bit has been sent.
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [3:0] length;
    logic       parity_type;
    logic       parity_en;
    logic       stop2;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start, tx_data, length, parity_type, parity_en, stop2,
        input  tx, tx_busy, tx_done
    );

    modport slave (
        input  tx_start, tx_data, length, parity_type, parity_en, stop2,
        output tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, 5..8 data bits LSB-first, optional
// parity, one or two stop bits. The serial line is driven from a register
// that is loaded with the bit value belonging to the next state.
module uart_tx
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = UART_TICKS_PER_BIT
) (
    input  logic        tx_clk,
    input  logic        rst,
    uart_tx_if.slave    bus,
    output uart_state_t state_dbg
);

    localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);

    uart_state_t   state, state_n;
    logic [TW-1:0] tick, tick_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    data_q, data_n;
    logic [3:0]    len_q, len_n;
    logic          ptype_q, ptype_n;
    logic          pen_q, pen_n;
    logic          stop2_q, stop2_n;
    logic          tx_q, tx_n;
    logic          bit_end;

    assign bit_end = (tick == TICK_LAST);

    // Next-state, counter and latched-frame logic; tx_n is the line value
    // that goes with the state being entered.
    always_comb begin
        state_n   = state;
        tick_n    = tick;
        bit_idx_n = bit_idx;
        data_n    = data_q;
        len_n     = len_q;
        ptype_n   = ptype_q;
        pen_n     = pen_q;
        stop2_n   = stop2_q;
        tx_n      = 1'b1;

        case (state)
            IDLE: begin
                tick_n    = '0;
                bit_idx_n = 3'd0;
                if (bus.tx_start && uart_len_ok(bus.length)) begin
                    data_n  = bus.tx_data;
                    len_n   = bus.length;
                    ptype_n = bus.parity_type;
                    pen_n   = bus.parity_en;
                    stop2_n = bus.stop2;
                    state_n = START;
                end
            end
            START: begin
                tick_n = bit_end ? '0 : tick + 1'b1;
                if (bit_end) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                tick_n = bit_end ? '0 : tick + 1'b1;
                if (bit_end) begin
                    if ({1'b0, bit_idx} == (len_q - 4'd1)) begin
                        bit_idx_n = 3'd0;
                        state_n   = pen_q ? PARITY : STOP1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                tick_n = bit_end ? '0 : tick + 1'b1;
                if (bit_end) begin
                    state_n = STOP1;
                end
            end
            STOP1: begin
                tick_n = bit_end ? '0 : tick + 1'b1;
                if (bit_end) begin
                    state_n = stop2_q ? STOP2 : DONE;
                end
            end
            STOP2: begin
                tick_n = bit_end ? '0 : tick + 1'b1;
                if (bit_end) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                tick_n  = '0;
                state_n = IDLE;
            end
            default: begin
                tick_n  = '0;
                state_n = IDLE;
            end
        endcase

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = data_n[bit_idx_n];
            PARITY:  tx_n = uart_parity(data_n, len_n, ptype_n);
            default: tx_n = 1'b1;
        endcase
    end

    // State, counters, latched frame settings and the registered line.
    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state   <= IDLE;
            tick    <= '0;
            bit_idx <= 3'd0;
            data_q  <= 8'd0;
            len_q   <= 4'd0;
            ptype_q <= 1'b0;
            pen_q   <= 1'b0;
            stop2_q <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            tick    <= tick_n;
            bit_idx <= bit_idx_n;
            data_q  <= data_n;
            len_q   <= len_n;
            ptype_q <= ptype_n;
            pen_q   <= pen_n;
            stop2_q <= stop2_n;
            tx_q    <= tx_n;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = (state != IDLE);
    assign bus.tx_done = (state == DONE);
    assign state_dbg   = state;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: directed frames with hand-computed line patterns,
// a framing sweep, illegal lengths, mid-frame reset and back-to-back starts.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int TPB = 16;

    // ---------------- clock / reset ----------------
    logic tx_clk = 1'b0;
    logic rst;
    always #5 tx_clk = ~tx_clk;

    uart_tx_if   bus();
    uart_state_t state_dbg;

    uart_tx #(.TICKS_PER_BIT(TPB)) dut (
        .tx_clk    (tx_clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int cyc = 0;
    always @(posedge tx_clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    // Entry: [15:12] number of line bits, [11:0] line bits, first bit at [0].
    logic [15:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int frames_pushed = 0;
    int done_count = 0;
    int last_done_cyc = -100;
    bit mon_en = 1'b1;
    bit b2b_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference line pattern for one frame.
    function automatic logic [15:0] frame_model(input logic [7:0] d, input int len,
                                                input bit pen, input bit pt, input bit s2);
        logic [11:0] b;
        int n;
        int ones;
        b = '0;
        n = 0;
        ones = 0;
        b[n] = 1'b0; n++;
        for (int i = 0; i < len; i++) begin
            b[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (pen) begin
            b[n] = pt ? ones[0] : ~ones[0];
            n++;
        end
        b[n] = 1'b1; n++;
        if (s2) begin
            b[n] = 1'b1; n++;
        end
        return {4'(n), b};
    endfunction

    // tx_done pulse counter
    always @(negedge tx_clk) begin
        if (bus.tx_done === 1'b1) begin
            done_count++;
            last_done_cyc = cyc;
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [15:0] e;
        logic [11:0] bits;
        int n;
        int errs;
        int guard;
        forever begin
            @(negedge tx_clk);
            if (mon_en && rst === 1'b0 && bus.tx === 1'b0) begin
                if (b2b_chk) begin
                    check("b2b_gap", cyc - last_done_cyc, 2);
                    b2b_chk = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    guard = 0;
                    while (bus.tx === 1'b0 && guard < 400) begin
                        @(negedge tx_clk);
                        guard++;
                    end
                end else begin
                    e = exp_q.pop_front();
                    n = int'(e[15:12]);
                    bits = e[11:0];
                    for (int i = 0; i < n; i++) begin
                        errs = 0;
                        for (int c = 0; c < TPB; c++) begin
                            if (i > 0 || c > 0) @(negedge tx_clk);
                            if (bus.tx !== bits[i] || bus.tx_done !== 1'b0 || bus.tx_busy !== 1'b1)
                                errs++;
                        end
                        check($sformatf("frame_bit%0d_errs", i), errs, 0);
                    end
                    @(negedge tx_clk);
                    check("frame_done_tx_busy", {29'd0, bus.tx_done, bus.tx, bus.tx_busy}, 3'b111);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge tx_clk);
        while (bus.tx_busy !== 1'b0 && n < 1000) begin
            @(negedge tx_clk);
            n++;
        end
        if (n >= 1000) check("idle_timeout", 1, 0);
    endtask

    task automatic send_frame(input logic [7:0] d, input int len, input bit pen,
                              input bit pt, input bit s2, input logic [15:0] exp);
        wait_idle();
        bus.tx_data     = d;
        bus.length      = 4'(len);
        bus.parity_en   = pen;
        bus.parity_type = pt;
        bus.stop2       = s2;
        bus.tx_start    = 1'b1;
        exp_q.push_back(exp);
        frames_pushed++;
        @(negedge tx_clk);
        check("launch_tx_busy", {30'd0, bus.tx, bus.tx_busy}, 2'b01);
        bus.tx_start    = 1'b0;
        bus.tx_data     = 8'($urandom);
        bus.length      = 4'($urandom_range(5, 8));
        bus.parity_en   = 1'($urandom);
        bus.parity_type = 1'($urandom);
        bus.stop2       = 1'($urandom);
    endtask

    task automatic bad_len(input logic [3:0] len);
        int errs;
        errs = 0;
        wait_idle();
        bus.length   = len;
        bus.tx_data  = 8'($urandom);
        bus.tx_start = 1'b1;
        repeat (20) begin
            @(negedge tx_clk);
            if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) errs++;
        end
        check($sformatf("bad_len_%0d_errs", len), errs, 0);
        bus.tx_start = 1'b0;
        bus.length   = 4'd8;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int n;
        int d0;
        rst             = 1'b1;
        bus.tx_start    = 1'b0;
        bus.tx_data     = 8'd0;
        bus.length      = 4'd8;
        bus.parity_en   = 1'b0;
        bus.parity_type = 1'b0;
        bus.stop2       = 1'b0;
        repeat (3) @(negedge tx_clk);
        check("reset_line", {29'd0, bus.tx, bus.tx_busy, bus.tx_done}, 3'b100);
        check("reset_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;

        // A5, 8 bits, odd-style parity (XOR), one stop: 0,1,0,1,0,0,1,0,1,0,1
        send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b0, 16'hB54A);
        // FF, 5 bits, XNOR parity, two stops: 0,1,1,1,1,1,0,1,1
        send_frame(8'hFF, 5, 1'b1, 1'b0, 1'b1, 16'h91BE);

        // Illegal lengths are ignored.
        bad_len(4'd4);
        bad_len(4'd9);
        bad_len(4'd0);
        bad_len(4'd15);

        // Reset mid-frame aborts without tx_done.
        wait_idle();
        mon_en          = 1'b0;
        bus.tx_data     = 8'hA5;
        bus.length      = 4'd8;
        bus.parity_en   = 1'b1;
        bus.parity_type = 1'b1;
        bus.stop2       = 1'b0;
        bus.tx_start    = 1'b1;
        @(negedge tx_clk);
        bus.tx_start = 1'b0;
        repeat (38) @(negedge tx_clk);
        d0  = done_count;
        rst = 1'b1;
        @(negedge tx_clk);
        check("abort_tx_busy", {30'd0, bus.tx, bus.tx_busy}, 2'b10);
        check("abort_state", 32'(state_dbg), 32'(IDLE));
        // Start together with reset: reset wins.
        bus.tx_start = 1'b1;
        @(negedge tx_clk);
        check("rst_vs_start", {30'd0, bus.tx, bus.tx_busy}, 2'b10);
        bus.tx_start = 1'b0;
        rst = 1'b0;
        repeat (250) @(negedge tx_clk);
        check("abort_no_done", done_count - d0, 0);
        mon_en = 1'b1;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, frame_model(8'h5A, 8, 1'b0, 1'b0, 1'b0));

        // Back-to-back with tx_start held and data changed mid-frame.
        // 3C, 6 bits -> 0,0,0,1,1,1,1,1 ; C3, 6 bits -> 0,1,1,0,0,0,0,1
        wait_idle();
        bus.tx_data     = 8'h3C;
        bus.length      = 4'd6;
        bus.parity_en   = 1'b0;
        bus.parity_type = 1'b0;
        bus.stop2       = 1'b0;
        bus.tx_start    = 1'b1;
        exp_q.push_back(16'h80F8);
        exp_q.push_back(16'h8086);
        frames_pushed += 2;
        @(negedge tx_clk);
        check("b2b_launch", {30'd0, bus.tx, bus.tx_busy}, 2'b01);
        bus.tx_data = 8'hC3;
        @(negedge tx_clk);
        b2b_chk = 1'b1;
        n = 0;
        while (bus.tx_done !== 1'b1 && n < 400) begin
            @(negedge tx_clk);
            n++;
        end
        if (n >= 400) check("b2b_done_timeout", 1, 0);
        @(posedge tx_clk);
        @(posedge tx_clk);
        @(negedge tx_clk);
        bus.tx_start = 1'b0;

        // Framing sweep with random data.
        for (int len = 5; len <= 8; len++) begin
            for (int pen = 0; pen < 2; pen++) begin
                for (int pt = 0; pt < 2; pt++) begin
                    for (int s2 = 0; s2 < 2; s2++) begin
                        logic [7:0] d;
                        d = 8'($urandom);
                        send_frame(d, len, pen[0], pt[0], s2[0],
                                   frame_model(d, len, pen[0], pt[0], s2[0]));
                    end
                end
            end
        end

        wait_idle();
        repeat (5) @(negedge tx_clk);
        check("queue_empty", exp_q.size(), 0);
        check("done_count", done_count, frames_pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
